// File: rtl/spi_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_arbiter_if
// Purpose  : Bundles the SPI command/response, host port and RAM port signals
//            of spi_ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_ram_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [7:0]        h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [7:0]        h_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              ram_re;
  logic [7:0]        ram_dout;
  logic              spi_ovf;

  // Arbiter side
  modport slave (
    input  rx_data, rx_valid, h_req, h_we, h_addr, h_wdata, ram_dout,
    output tx_data, tx_valid, h_gnt, h_rvalid, h_rdata,
           ram_addr, ram_din, ram_we, ram_re, spi_ovf
  );

  // Environment side (SPI slave, host, RAM)
  modport master (
    output rx_data, rx_valid, h_req, h_we, h_addr, h_wdata, ram_dout,
    input  tx_data, tx_valid, h_gnt, h_rvalid, h_rdata,
           ram_addr, ram_din, ram_we, ram_re, spi_ovf
  );
endinterface
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_arbiter
// Purpose  : Round-robin arbitration of SPI commands and host requests onto a
//            single-port RAM. Optional macro ADDR_AUTOINC_EN enables address
//            auto-increment after each granted SPI access.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_arbiter_if.slave bus
);

`ifdef ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] OP_LD_WADDR = 2'b00;
  localparam logic [1:0] OP_LD_RADDR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              pend_q, pend_d;
  logic              pend_rd_q, pend_rd_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              ovf_q, ovf_d;
  logic              last_host_q, last_host_d;   // 0: SPI granted last
  logic              sel_spi_q, sel_spi_d;
  logic              rd_q, rd_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              in_access;
  logic              in_resp;
  logic              spi_grant;

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign spi_grant = in_access && sel_spi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      pend_q      <= 1'b0;
      pend_rd_q   <= 1'b0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
      ovf_q       <= 1'b0;
      last_host_q <= 1'b0;
      sel_spi_q   <= 1'b0;
      rd_q        <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      pend_q      <= pend_d;
      pend_rd_q   <= pend_rd_d;
      pend_data_q <= pend_data_d;
      pend_addr_q <= pend_addr_d;
      ovf_q       <= ovf_d;
      last_host_q <= last_host_d;
      sel_spi_q   <= sel_spi_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    pend_d      = pend_q;
    pend_rd_d   = pend_rd_q;
    pend_data_d = pend_data_q;
    pend_addr_d = pend_addr_q;
    ovf_d       = ovf_q;
    last_host_d = last_host_q;
    sel_spi_d   = sel_spi_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q || bus.h_req) begin
          state_d     = ACCESS;
          // On a tie the requester that was not granted last wins.
          sel_spi_d   = (pend_q && bus.h_req) ? last_host_q : pend_q;
          rd_d        = sel_spi_d ? pend_rd_q : !bus.h_we;
          last_host_d = !sel_spi_d;
        end
      end
      ACCESS:  state_d = rd_q ? RD_WAIT : IDLE;
      RD_WAIT: begin
        rdata_d = bus.ram_dout;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (spi_grant) begin
      pend_d = 1'b0;
      if (AUTOINC) begin
        if (rd_q) raddr_d = raddr_q + ADDR_W'(1);
        else      waddr_d = waddr_q + ADDR_W'(1);
      end
    end

    // Capture uses the post-increment address so a command accepted in the
    // same cycle as a granted SPI access sees the updated pointer.
    if (bus.rx_valid) begin
      if (bus.rx_data[9:8] == OP_LD_WADDR) begin
        waddr_d = ADDR_W'(bus.rx_data[7:0]);
      end else if (bus.rx_data[9:8] == OP_LD_RADDR) begin
        raddr_d = ADDR_W'(bus.rx_data[7:0]);
      end else if (pend_d) begin
        ovf_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_rd_d   = bus.rx_data[9];
        pend_data_d = bus.rx_data[7:0];
        pend_addr_d = bus.rx_data[9] ? raddr_d : waddr_d;
      end
    end
  end

  assign bus.ram_we   = in_access && !rd_q;
  assign bus.ram_re   = in_access && rd_q;
  assign bus.ram_addr = !in_access ? '0 : (sel_spi_q ? pend_addr_q : bus.h_addr);
  assign bus.ram_din  = !(in_access && !rd_q) ? '0 : (sel_spi_q ? pend_data_q : bus.h_wdata);
  assign bus.h_gnt    = in_access && !sel_spi_q;
  assign bus.tx_valid = in_resp && sel_spi_q;
  assign bus.tx_data  = (in_resp && sel_spi_q) ? rdata_q : '0;
  assign bus.h_rvalid = in_resp && !sel_spi_q;
  assign bus.h_rdata  = (in_resp && !sel_spi_q) ? rdata_q : '0;
  assign bus.spi_ovf  = ovf_q;

endmodule
`default_nettype wire
